// File: rtl/color_wheel_fader.sv
// Hue-wheel RGB duty generator: ramps through six segments, one INC step per prescaler tick.
// Optional FADER_REVERSE_EN adds a dir input that lets the wheel step backwards.
module color_wheel_fader #(
   parameter int unsigned PWM_INTERVAL = 1200,
   parameter int unsigned STEP_CYCLES  = 20000,
   parameter int unsigned INC          = 12,
   localparam int unsigned W           = $clog2(PWM_INTERVAL + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
`ifdef FADER_REVERSE_EN
   input  logic         dir,
`endif
   output logic [W-1:0] r_duty,
   output logic [W-1:0] g_duty,
   output logic [W-1:0] b_duty,
   output logic         duty_stb,
   output logic [2:0]   seg
);

   localparam int unsigned PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [W:0] MaxW1 = (W + 1)'(PWM_INTERVAL);
   localparam logic [W:0] IncW1 = (W + 1)'(INC);

   logic [PW-1:0] presc_q, presc_d;
   logic [W-1:0]  ramp_q, ramp_d;
   logic [2:0]    seg_q, seg_d;
   logic [W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic          tick, tick_q, stb_q;
   logic          rev;
   logic [W:0]    ramp_inc, rise, fall;

`ifdef FADER_REVERSE_EN
   assign rev = dir;
`else
   assign rev = 1'b0;
`endif

   always_comb begin
      tick     = en && (presc_q == PW'(STEP_CYCLES - 1));
      presc_d  = presc_q;
      ramp_d   = ramp_q;
      seg_d    = seg_q;
      ramp_inc = {1'b0, ramp_q} + IncW1;
      if (en) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
         if (rev) begin
            if (ramp_q == '0) begin
               seg_d  = (seg_q == 3'd0) ? 3'd5 : seg_q - 3'd1;
               ramp_d = W'(MaxW1 - IncW1);
            end else begin
               ramp_d = W'({1'b0, ramp_q} - IncW1);
            end
         end else if (ramp_inc >= MaxW1) begin
            ramp_d = '0;
            seg_d  = (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
         end else begin
            ramp_d = W'(ramp_inc);
         end
      end
   end

   // Duties follow the current state, so they trail the tick edge by one clock.
   always_comb begin
      rise = {1'b0, ramp_q};
      fall = MaxW1 - rise;
      r_d  = W'(MaxW1);
      g_d  = '0;
      b_d  = '0;
      unique case (seg_q)
         3'd0: begin r_d = W'(MaxW1); g_d = W'(rise);  b_d = '0;         end
         3'd1: begin r_d = W'(fall);  g_d = W'(MaxW1); b_d = '0;         end
         3'd2: begin r_d = '0;        g_d = W'(MaxW1); b_d = W'(rise);   end
         3'd3: begin r_d = '0;        g_d = W'(fall);  b_d = W'(MaxW1);  end
         3'd4: begin r_d = W'(rise);  g_d = '0;        b_d = W'(MaxW1);  end
         3'd5: begin r_d = W'(MaxW1); g_d = '0;        b_d = W'(fall);   end
         default: begin r_d = W'(MaxW1); g_d = '0;     b_d = '0;         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         ramp_q  <= '0;
         seg_q   <= 3'd0;
         r_q     <= W'(MaxW1);
         g_q     <= '0;
         b_q     <= '0;
         tick_q  <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         ramp_q  <= ramp_d;
         seg_q   <= seg_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         tick_q  <= tick;
         stb_q   <= tick_q;
      end
   end

   assign r_duty   = r_q;
   assign g_duty   = g_q;
   assign b_duty   = b_q;
   assign duty_stb = stb_q;
   assign seg      = seg_q;

endmodule

// File: tb/tb_color_wheel_fader.sv
// Directed bench for color_wheel_fader at PWM_INTERVAL=12, STEP_CYCLES=4, INC=3.
module tb_color_wheel_fader;
   localparam int PI  = 12;
   localparam int SC  = 4;
   localparam int INC = 3;

   logic       clk = 1'b0;
   logic       rst, en;
   logic       dir;
   logic [3:0] r, g, b;
   logic       stb;
   logic [2:0] seg;

   int n_checks = 0;
   int n_fail   = 0;
   int m_seg, m_ramp, e_r, e_g, e_b, p_r, p_g, p_b;
   int cyc;

   color_wheel_fader #(.PWM_INTERVAL(PI), .STEP_CYCLES(SC), .INC(INC)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
`ifdef FADER_REVERSE_EN
      .dir      (dir),
`endif
      .r_duty   (r),
      .g_duty   (g),
      .b_duty   (b),
      .duty_stb (stb),
      .seg      (seg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int absd(input int a, input int c);
      return (a > c) ? a - c : c - a;
   endfunction

   task automatic model_tick(input bit rev);
      if (rev) begin
         if (m_ramp == 0) begin
            m_seg  = (m_seg == 0) ? 5 : m_seg - 1;
            m_ramp = PI - INC;
         end else begin
            m_ramp = m_ramp - INC;
         end
      end else if (m_ramp + INC >= PI) begin
         m_ramp = 0;
         m_seg  = (m_seg + 1) % 6;
      end else begin
         m_ramp = m_ramp + INC;
      end
   endtask

   task automatic model_duty();
      int rise, fall;
      rise = m_ramp;
      fall = PI - m_ramp;
      case (m_seg)
         0: begin e_r = PI;   e_g = rise; e_b = 0;    end
         1: begin e_r = fall; e_g = PI;   e_b = 0;    end
         2: begin e_r = 0;    e_g = PI;   e_b = rise; end
         3: begin e_r = 0;    e_g = fall; e_b = PI;   end
         4: begin e_r = rise; e_g = 0;    e_b = PI;   end
         default: begin e_r = PI; e_g = 0; e_b = fall; end
      endcase
   endtask

   task automatic model_reset();
      m_seg = 0; m_ramp = 0;
      p_r = PI; p_g = 0; p_b = 0;
      model_duty();
   endtask

   task automatic wait_stb(input int budget, output int cycles);
      bit seen;
      seen   = 1'b0;
      cycles = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         cycles++;
         if (stb === 1'b1) seen = 1'b1;
      end
      if (!seen) check("stb_timeout", 0, 1);
   endtask

   task automatic check_update(input string tag);
      model_duty();
      check({tag, "_r"}, r, e_r);
      check({tag, "_g"}, g, e_g);
      check({tag, "_b"}, b, e_b);
      check({tag, "_seg"}, seg, m_seg);
      check({tag, "_dr"}, absd(int'(r), p_r) <= INC, 1);
      check({tag, "_dg"}, absd(int'(g), p_g) <= INC, 1);
      check({tag, "_db"}, absd(int'(b), p_b) <= INC, 1);
      p_r = e_r; p_g = e_g; p_b = e_b;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; dir = 1'b0;
      repeat (3) step();
      check("rst_r", r, PI);
      check("rst_g", g, 0);
      check("rst_b", b, 0);
      check("rst_seg", seg, 0);
      check("rst_stb", stb, 0);
      model_reset();

      // First step lands on the 5th edge after release.
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         check("stb_early", stb, 0);
      end
      step();
      check("first_stb", stb, 1);
      check("first_g", g, 3);
      check("first_r", r, PI);
      check("first_b", b, 0);
      model_tick(1'b0);
      check_update("first");

      for (int t = 2; t <= 24; t++) begin
         wait_stb(10, cyc);
         check("stb_period", cyc, SC);
         model_tick(1'b0);
         check_update("wrap");
         if (t == 4) begin
            check("t4_seg", seg, 1);
            check("t4_r", r, 12);
            check("t4_g", g, 12);
         end
         if (t == 24) begin
            check("t24_seg", seg, 0);
            check("t24_r", r, 12);
            check("t24_g", g, 0);
            check("t24_b", b, 0);
         end
      end

      // Freeze with prescaler at 2.
      step();
      en = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         check("pause_stb", stb, 0);
         check("pause_r", r, e_r);
         check("pause_g", g, e_g);
         check("pause_b", b, e_b);
      end
      en = 1'b1;
      step();
      check("resume_stb1", stb, 0);
      step();
      check("resume_stb2", stb, 0);
      step();
      check("resume_stb3", stb, 1);
      model_tick(1'b0);
      check_update("resume");

      for (int i = 0; i < 30 && !(m_seg == 3 && m_ramp == 6); i++) begin
         wait_stb(10, cyc);
         model_tick(1'b0);
         check_update("run");
      end
      check("reach_seg3", seg, 3);
      step();
      rst = 1'b1;
      step();
      check("mid_rst_r", r, PI);
      check("mid_rst_g", g, 0);
      check("mid_rst_b", b, 0);
      check("mid_rst_seg", seg, 0);
      check("mid_rst_stb", stb, 0);

      // Reset asserted exactly on a tick cycle must win.
      rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      check("tick_rst_seg", seg, 0);
      step();
      check("tick_rst_stb", stb, 0);
      check("tick_rst_g", g, 0);
      rst = 1'b0;
      model_reset();
      wait_stb(10, cyc);
      check("rerun_latency", cyc, 5);
      model_tick(1'b0);
      check_update("rerun");

`ifdef FADER_REVERSE_EN
      rst = 1'b1; dir = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      model_reset();
      wait_stb(10, cyc);
      model_tick(1'b1);
      check_update("rev");
      check("rev_seg", seg, 5);
      check("rev_r", r, 12);
      check("rev_b", b, 3);
      check("rev_g", g, 0);
      dir = 1'b0;
      wait_stb(10, cyc);
      check("flip_period", cyc, SC);
      model_tick(1'b0);
      check_update("flip");
      check("flip_seg", seg, 0);
      check("flip_r", r, 12);
      check("flip_g", g, 0);
      check("flip_b", b, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/color_wheel_fader.md
COLOR_WHEEL_FADER -- requirements
Module: color_wheel_fader

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200: full-scale duty value, in clocks, of the downstream PWM period.
REQ-002 SHALL have parameter STEP_CYCLES, default 20000: clocks between ramp steps.
REQ-003 SHALL have parameter INC, default 12: duty increment per step; 0 < INC <= PWM_INTERVAL and PWM_INTERVAL % INC == 0.
REQ-004 SHALL define W = $clog2(PWM_INTERVAL+1) as the duty width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  advance enable; 0 freezes the prescaler and the ramp.
REQ-008 r_duty  output  W  red duty value, 0..PWM_INTERVAL.
REQ-009 g_duty  output  W  green duty value, 0..PWM_INTERVAL.
REQ-010 b_duty  output  W  blue duty value, 0..PWM_INTERVAL.
REQ-011 duty_stb  output  1  one-cycle pulse when new duty values appear.
REQ-012 seg  output  3  current hue segment, 0..5.

Function
REQ-013 Prescaler SHALL count 0..STEP_CYCLES-1 while en=1, wrap to 0, and hold while en=0; tick = (prescaler == STEP_CYCLES-1) && en.
REQ-014 On tick (forward), if ramp+INC >= PWM_INTERVAL then ramp <= 0 and seg <= seg+1 (5 wraps to 0); else ramp <= ramp+INC.
REQ-015 Segment map (rise = ramp, fall = PWM_INTERVAL-ramp, max = PWM_INTERVAL): 0: R=max, G=rise, B=0; 1: R=fall, G=max, B=0; 2: G=max, B=rise, R=0; 3: G=fall, B=max, R=0; 4: B=max, R=rise, G=0; 5: B=fall, R=max, G=0.
REQ-016 Duty outputs SHALL be registered: values from the seg/ramp state produced by a tick appear one clock after that tick edge.
REQ-017 duty_stb SHALL be high for exactly the cycle in which the updated duty values first appear, and low otherwise.
REQ-018 At segment boundaries, the duty values SHALL be continuous; no output SHALL jump by more than INC between consecutive updates.
REQ-019 Duty outputs SHALL never exceed PWM_INTERVAL; arithmetic SHALL be done at W+1 bits to avoid overflow.
REQ-020 Deasserting en SHALL preserve the partial prescaler count; on re-enable, counting SHALL resume from the held value.

Reset
REQ-021 While rst=1 at a clock edge: prescaler=0, ramp=0, seg=0, r_duty=PWM_INTERVAL, g_duty=0, b_duty=0, duty_stb=0.
REQ-022 rst SHALL take priority over en and tick, including mid-segment and on a tick cycle.

Configuration
REQ-023 Macro FADER_REVERSE_EN: when defined, the block SHALL add input port dir (1 bit, after en).
REQ-024 With FADER_REVERSE_EN and dir=1, on tick: if ramp == 0 then seg <= seg-1 (0 wraps to 5) and ramp <= PWM_INTERVAL-INC; else ramp <= ramp-INC.
REQ-025 With FADER_REVERSE_EN and dir=0, or with the macro undefined, the block SHALL step forward only, and the dir port SHALL be absent when the macro is undefined.
REQ-026 A change of dir SHALL take effect at the next tick, with no skipped or repeated duty values.

Verification (PWM_INTERVAL=12, STEP_CYCLES=4, INC=3)
REQ-027 Reset: hold rst for 3 clocks -> R=12, G=0, B=0, seg=0, duty_stb=0.
REQ-028 First step: release rst with en=1 -> duty_stb pulses and G=3 on the 5th rising edge after release; R=12, B=0.
REQ-029 Wrap: after 4 ticks -> seg=1, R=12, G=12; after 24 ticks (96 clocks) -> seg=0, R=12, G=0, B=0; check every update for |delta| <= 3.
REQ-030 Pause: drop en for 50 clocks after prescaler=2 -> no duty_stb and outputs frozen; after re-enable, the next tick occurs 2 clocks later.
REQ-031 Mid-run reset: assert rst in seg=3 -> next edge gives R=12, G=0, B=0, seg=0, duty_stb=0.
REQ-032 FADER_REVERSE_EN with dir=1 from reset -> first tick gives seg=5, R=12, B=3, G=0; a flip to dir=0 at the next tick gives seg=0, R=12, G=0, B=0.
